// File: rtl/seqtest.sv
// seqtest: clocked stimulus generator and checker for pipelined DUTs.
//
// Issues one input vector per slot (exhaustive count or Galois LFSR) and
// captures the combinational golden-model output in the same slot. Each
// expected value travels down a LATENCY-deep delay line and is compared
// 4-state (case inequality) against dut_out when it reaches the tail.
// Mismatches are counted (saturating), the first one is captured, and the
// run ends in DONE with pass = (err_count == 0).
//
// Ports:
//   clk           in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   begin a run (honoured in IDLE or DONE only)
//   dut_in        out  vector to DUT and golden model (x outside slots)
//   dut_valid     out  dut_in holds a real vector this cycle
//   ref_out       in   golden-model output for the current dut_in
//   dut_out       in   DUT output
//   busy          out  run in progress (RUN or DRAIN)
//   done          out  run finished
//   pass          out  done and err_count == 0
//   err_count     out  saturating mismatch count
//   fail_vector   out  dut_in of the first mismatch
//   fail_expected out  expected value at the first mismatch
//   fail_got      out  dut_out at the first mismatch
module seqtest #(
  parameter int unsigned       INBITS     = 8,
  parameter int unsigned       OUTBITS    = 8,
  parameter int unsigned       LATENCY    = 2,
  parameter int unsigned       GAP        = 0,
  parameter int unsigned       MODE       = 0,
  parameter int unsigned       COUNT      = 256,
  parameter logic [INBITS-1:0] SEED       = 8'h01,
  parameter logic [INBITS-1:0] POLY       = 8'hB8,
  parameter int unsigned       MAX_ERRORS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [INBITS-1:0]  dut_in,
  output logic               dut_valid,
  input  logic [OUTBITS-1:0] ref_out,
  input  logic [OUTBITS-1:0] dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [31:0]        err_count,
  output logic [INBITS-1:0]  fail_vector,
  output logic [OUTBITS-1:0] fail_expected,
  output logic [OUTBITS-1:0] fail_got
);

  // Total vectors in one run; 33 bits so that 2^32 is representable.
  localparam logic [32:0] NUM_VEC  = (MODE == 0) ? (33'd1 << INBITS) : 33'(COUNT);
  // The delay line keeps at least one stage so LATENCY=0 needs no special arrays.
  localparam int unsigned DL_DEPTH = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [31:0] GAP_L    = 32'(GAP);
  localparam logic [31:0] LAT_L    = 32'(LATENCY);
  localparam logic [31:0] MAX_L    = 32'(MAX_ERRORS);
  localparam logic [INBITS-1:0] FIRST_VEC = (MODE == 0) ? {INBITS{1'b0}} : SEED;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Next vector in the configured sequence.
  function automatic logic [INBITS-1:0] next_vec(input logic [INBITS-1:0] v);
    if (MODE == 0) begin
      return v + {{(INBITS-1){1'b0}}, 1'b1};
    end else begin
      return (v >> 1) ^ (v[0] ? POLY : {INBITS{1'b0}});
    end
  endfunction

  state_t               state_r, state_n;
  logic [INBITS-1:0]    vec_r, vec_n;
  logic [32:0]          idx_r, idx_n;         // vectors issued, including the current one
  logic [31:0]          gap_cnt_r, gap_cnt_n;
  logic [31:0]          drain_cnt_r, drain_cnt_n;
  logic                 valid_r, valid_n;
  logic [31:0]          err_count_r, err_count_n;
  logic [INBITS-1:0]    fail_vector_r, fail_vector_n;
  logic [OUTBITS-1:0]   fail_expected_r, fail_expected_n;
  logic [OUTBITS-1:0]   fail_got_r, fail_got_n;
  logic                 busy_r, busy_n;
  logic                 done_r, done_n;
  logic                 pass_r, pass_n;
  logic                 dl_clear_s;
  logic                 dl_shift_s;

  logic                 dl_valid_r [DL_DEPTH];
  logic [OUTBITS-1:0]   dl_exp_r   [DL_DEPTH];
  logic [INBITS-1:0]    dl_vec_r   [DL_DEPTH];

  logic                 chk_valid_s;
  logic [OUTBITS-1:0]   chk_exp_s;
  logic [INBITS-1:0]    chk_vec_s;
  logic                 mismatch_s;
  logic [31:0]          err_inc_s;

  // Select the entry being checked this cycle: the delay-line tail, or the
  // live slot when the DUT is combinational.
  always_comb begin
    if (LATENCY == 0) begin
      chk_valid_s = valid_r;
      chk_exp_s   = ref_out;
      chk_vec_s   = vec_r;
    end else begin
      chk_valid_s = dl_valid_r[DL_DEPTH-1];
      chk_exp_s   = dl_exp_r[DL_DEPTH-1];
      chk_vec_s   = dl_vec_r[DL_DEPTH-1];
    end
  end

  // 4-state compare of a valid checked entry; x/z on dut_out counts as a miss.
  always_comb begin
    mismatch_s = 1'b0;
    if ((state_r == S_RUN || state_r == S_DRAIN) && chk_valid_s) begin
      mismatch_s = (dut_out !== chk_exp_s);
    end else begin
      mismatch_s = 1'b0;
    end
    err_inc_s = (err_count_r == 32'hFFFF_FFFF) ? err_count_r : (err_count_r + 32'd1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n         = state_r;
    vec_n           = vec_r;
    idx_n           = idx_r;
    gap_cnt_n       = gap_cnt_r;
    drain_cnt_n     = drain_cnt_r;
    valid_n         = valid_r;
    err_count_n     = err_count_r;
    fail_vector_n   = fail_vector_r;
    fail_expected_n = fail_expected_r;
    fail_got_n      = fail_got_r;
    dl_clear_s      = 1'b0;
    dl_shift_s      = 1'b0;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Full restart: everything from a previous run is discarded.
          state_n         = S_RUN;
          vec_n           = FIRST_VEC;
          idx_n           = 33'd1;
          gap_cnt_n       = 32'd0;
          drain_cnt_n     = 32'd0;
          valid_n         = 1'b1;
          err_count_n     = 32'd0;
          fail_vector_n   = {INBITS{1'b0}};
          fail_expected_n = {OUTBITS{1'b0}};
          fail_got_n      = {OUTBITS{1'b0}};
          dl_clear_s      = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      S_RUN: begin
        dl_shift_s = 1'b1;
        if (valid_r) begin
          if (idx_r == NUM_VEC) begin
            // Last slot just issued; with no pipeline it is also checked now.
            valid_n     = 1'b0;
            drain_cnt_n = 32'd1;
            state_n     = (LATENCY == 0) ? S_DONE : S_DRAIN;
          end else if (GAP == 0) begin
            valid_n = 1'b1;
            vec_n   = next_vec(vec_r);
            idx_n   = idx_r + 33'd1;
          end else begin
            valid_n   = 1'b0;
            gap_cnt_n = 32'd1;
          end
        end else begin
          if (gap_cnt_r == GAP_L) begin
            valid_n = 1'b1;
            vec_n   = next_vec(vec_r);
            idx_n   = idx_r + 33'd1;
          end else begin
            gap_cnt_n = gap_cnt_r + 32'd1;
          end
        end
      end
      S_DRAIN: begin
        // drain_cnt_r counts edges since the last slot; LATENCY of them
        // brings the last vector to the tail.
        dl_shift_s = 1'b1;
        if (drain_cnt_r == LAT_L) begin
          state_n = S_DONE;
        end else begin
          drain_cnt_n = drain_cnt_r + 32'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        valid_n = 1'b0;
      end
    endcase

    // Mismatch bookkeeping overrides the sequencing above, so a miss on the
    // final check is counted before DONE/pass are evaluated.
    if (mismatch_s) begin
      err_count_n = err_inc_s;
      if (err_count_r == 32'd0) begin
        fail_vector_n   = chk_vec_s;
        fail_expected_n = chk_exp_s;
        fail_got_n      = dut_out;
      end else begin
        fail_vector_n   = fail_vector_r;
      end
      if ((MAX_ERRORS != 0) && (err_inc_s == MAX_L)) begin
        state_n = S_DONE;
        valid_n = 1'b0;
      end else begin
        state_n = state_n;
      end
    end else begin
      err_count_n = err_count_n;
    end

    busy_n = (state_n == S_RUN) || (state_n == S_DRAIN);
    done_n = (state_n == S_DONE);
    pass_n = (state_n == S_DONE) && (err_count_n == 32'd0);
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      vec_r           <= {INBITS{1'b0}};
      idx_r           <= 33'd0;
      gap_cnt_r       <= 32'd0;
      drain_cnt_r     <= 32'd0;
      valid_r         <= 1'b0;
      err_count_r     <= 32'd0;
      fail_vector_r   <= {INBITS{1'b0}};
      fail_expected_r <= {OUTBITS{1'b0}};
      fail_got_r      <= {OUTBITS{1'b0}};
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
    end else begin
      state_r         <= state_n;
      vec_r           <= vec_n;
      idx_r           <= idx_n;
      gap_cnt_r       <= gap_cnt_n;
      drain_cnt_r     <= drain_cnt_n;
      valid_r         <= valid_n;
      err_count_r     <= err_count_n;
      fail_vector_r   <= fail_vector_n;
      fail_expected_r <= fail_expected_n;
      fail_got_r      <= fail_got_n;
      busy_r          <= busy_n;
      done_r          <= done_n;
      pass_r          <= pass_n;
    end
  end

  // Expected-value delay line; stage 0 receives the current cycle's entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DL_DEPTH; i++) begin
        dl_valid_r[i] <= 1'b0;
        dl_exp_r[i]   <= {OUTBITS{1'b0}};
        dl_vec_r[i]   <= {INBITS{1'b0}};
      end
    end else if (dl_clear_s) begin
      for (int i = 0; i < DL_DEPTH; i++) begin
        dl_valid_r[i] <= 1'b0;
        dl_exp_r[i]   <= {OUTBITS{1'b0}};
        dl_vec_r[i]   <= {INBITS{1'b0}};
      end
    end else if (dl_shift_s) begin
      dl_valid_r[0] <= valid_r;
      dl_exp_r[0]   <= ref_out;
      dl_vec_r[0]   <= vec_r;
      for (int i = 1; i < DL_DEPTH; i++) begin
        dl_valid_r[i] <= dl_valid_r[i-1];
        dl_exp_r[i]   <= dl_exp_r[i-1];
        dl_vec_r[i]   <= dl_vec_r[i-1];
      end
    end else begin
      for (int i = 0; i < DL_DEPTH; i++) begin
        dl_valid_r[i] <= dl_valid_r[i];
        dl_exp_r[i]   <= dl_exp_r[i];
        dl_vec_r[i]   <= dl_vec_r[i];
      end
    end
  end

  assign dut_in        = valid_r ? vec_r : {INBITS{1'bx}};
  assign dut_valid     = valid_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign err_count     = err_count_r;
  assign fail_vector   = fail_vector_r;
  assign fail_expected = fail_expected_r;
  assign fail_got      = fail_got_r;

endmodule

// File: tb/tb_seqtest.sv
// Self-checking bench for seqtest: five instances with different
// configurations, each driving a small behavioural DUT model.
module tb_seqtest;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       start_m [0:4];
  logic       done_m  [0:4];
  logic       valid_m [0:4];
  logic [7:0] din_m   [0:4];
  logic [7:0] seen_q  [$];

  // ---------------- instance 0: 4-bit, LATENCY 2, exhaustive ----------------
  logic [3:0] dut_in0, ref_out0, dut_out0, fv0, fe0, fg0, p0a, p0b;
  logic       dut_valid0, busy0, done0, pass0;
  logic [31:0] err0;
  logic [3:0] f0_vec, f0_xor;
  always @(posedge clk) begin
    p0a <= (dut_in0 == f0_vec) ? (dut_in0 ^ f0_xor) : dut_in0;
    p0b <= p0a;
  end
  assign ref_out0 = dut_in0;
  assign dut_out0 = p0b;
  seqtest #(.INBITS(4), .OUTBITS(4), .LATENCY(2), .GAP(0), .MODE(0), .COUNT(16),
            .SEED(4'h1), .POLY(4'h9), .MAX_ERRORS(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_m[0]), .dut_in(dut_in0), .dut_valid(dut_valid0),
    .ref_out(ref_out0), .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vector(fv0), .fail_expected(fe0), .fail_got(fg0));

  // ---------------- instance 1: abort after first error ----------------
  logic [3:0] dut_in1, ref_out1, dut_out1, fv1, fe1, fg1, p1a, p1b;
  logic       dut_valid1, busy1, done1, pass1;
  logic [31:0] err1;
  always @(posedge clk) begin
    p1a <= ~dut_in1;
    p1b <= p1a;
  end
  assign ref_out1 = dut_in1;
  assign dut_out1 = p1b;
  seqtest #(.INBITS(4), .OUTBITS(4), .LATENCY(2), .GAP(0), .MODE(0), .COUNT(16),
            .SEED(4'h1), .POLY(4'h9), .MAX_ERRORS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_m[1]), .dut_in(dut_in1), .dut_valid(dut_valid1),
    .ref_out(ref_out1), .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vector(fv1), .fail_expected(fe1), .fail_got(fg1));

  // ---------------- instance 2: LFSR, 5 vectors, LATENCY 1 ----------------
  logic [7:0] dut_in2, ref_out2, dut_out2, fv2, fe2, fg2, p2;
  logic       dut_valid2, busy2, done2, pass2;
  logic [31:0] err2;
  always @(posedge clk) p2 <= dut_in2;
  assign ref_out2 = dut_in2;
  assign dut_out2 = p2;
  seqtest #(.INBITS(8), .OUTBITS(8), .LATENCY(1), .GAP(0), .MODE(1), .COUNT(5),
            .SEED(8'h01), .POLY(8'hB8), .MAX_ERRORS(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_m[2]), .dut_in(dut_in2), .dut_valid(dut_valid2),
    .ref_out(ref_out2), .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vector(fv2), .fail_expected(fe2), .fail_got(fg2));

  // ---------------- instance 3: LATENCY 0, GAP 1, x injection ----------------
  logic [3:0] dut_in3, ref_out3, dut_out3, fv3, fe3, fg3;
  logic       dut_valid3, busy3, done3, pass3, x3_en;
  logic [31:0] err3;
  assign ref_out3 = dut_in3;
  assign dut_out3 = (x3_en && dut_in3 == 4'd7) ? 4'bxxxx : dut_in3;
  seqtest #(.INBITS(4), .OUTBITS(4), .LATENCY(0), .GAP(1), .MODE(0), .COUNT(16),
            .SEED(4'h1), .POLY(4'h9), .MAX_ERRORS(0)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_m[3]), .dut_in(dut_in3), .dut_valid(dut_valid3),
    .ref_out(ref_out3), .dut_out(dut_out3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_vector(fv3), .fail_expected(fe3), .fail_got(fg3));

  // ---------------- instance 4: LFSR, GAP 2, LATENCY 3, abort at 3 ----------------
  logic [7:0] dut_in4, ref_out4, dut_out4, fv4, fe4, fg4, p4a, p4b, p4c;
  logic       dut_valid4, busy4, done4, pass4;
  logic [31:0] err4;
  logic [7:0] f4 [0:255];
  always @(posedge clk) begin
    p4a <= dut_in4 ^ f4[dut_in4];
    p4b <= p4a;
    p4c <= p4b;
  end
  assign ref_out4 = dut_in4;
  assign dut_out4 = p4c;
  seqtest #(.INBITS(8), .OUTBITS(8), .LATENCY(3), .GAP(2), .MODE(1), .COUNT(20),
            .SEED(8'h5A), .POLY(8'hB8), .MAX_ERRORS(3)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_m[4]), .dut_in(dut_in4), .dut_valid(dut_valid4),
    .ref_out(ref_out4), .dut_out(dut_out4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .fail_vector(fv4), .fail_expected(fe4), .fail_got(fg4));

  assign done_m[0] = done0;  assign valid_m[0] = dut_valid0;  assign din_m[0] = {4'h0, dut_in0};
  assign done_m[1] = done1;  assign valid_m[1] = dut_valid1;  assign din_m[1] = {4'h0, dut_in1};
  assign done_m[2] = done2;  assign valid_m[2] = dut_valid2;  assign din_m[2] = dut_in2;
  assign done_m[3] = done3;  assign valid_m[3] = dut_valid3;  assign din_m[3] = {4'h0, dut_in3};
  assign done_m[4] = done4;  assign valid_m[4] = dut_valid4;  assign din_m[4] = dut_in4;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Pulse start (caller sits at a negedge), then count edges until done,
  // recording every vector seen while dut_valid is high.
  task automatic run(input int sel, input int limit, output int edges, output int vcnt);
    start_m[sel] = 1'b1;
    @(negedge clk);
    start_m[sel] = 1'b0;
    seen_q.delete();
    edges = 0;
    vcnt = 0;
    while (done_m[sel] !== 1'b1 && edges < limit) begin
      if (valid_m[sel] === 1'b1) begin
        vcnt++;
        seen_q.push_back(din_m[sel]);
      end
      @(negedge clk);
      edges++;
    end
    if (done_m[sel] !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL run%0d timeout: done not seen after %0d edges", sel, limit);
    end
  endtask

  typedef struct {
    logic [3:0] fvec;
    logic [3:0] fxor;
    int         exp_err;
    logic       exp_pass;
    logic [3:0] exp_fv;
    logic [3:0] exp_fe;
    logic [3:0] exp_fg;
  } rec_t;

  initial begin
    rec_t       tbl [5];
    int         edges, vcnt, bad;
    logic [7:0] seq [20];
    logic [7:0] v;
    int         nf, first_k, abort_k, exp_edges, exp_vcnt;
    logic [3:0] rv, rx;

    tbl[0] = '{4'd0,  4'h0, 0, 1'b1, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{4'd9,  4'h1, 1, 1'b0, 4'h9, 4'h9, 4'h8};
    tbl[2] = '{4'd0,  4'hF, 1, 1'b0, 4'h0, 4'h0, 4'hF};
    tbl[3] = '{4'd15, 4'h8, 1, 1'b0, 4'hF, 4'hF, 4'h7};
    tbl[4] = '{4'd5,  4'h2, 1, 1'b0, 4'h5, 4'h5, 4'h7};

    for (int i = 0; i < 5; i++) start_m[i] = 1'b0;
    for (int i = 0; i < 256; i++) f4[i] = 8'h00;
    f0_vec = 4'd0; f0_xor = 4'h0; x3_en = 1'b0;

    // Reset state
    rst_n = 1'b0;
    #1;
    chk("reset busy", {63'd0, busy0}, 64'd0);
    chk("reset done", {63'd0, done0}, 64'd0);
    chk("reset pass", {63'd0, pass0}, 64'd0);
    chk("reset valid", {63'd0, dut_valid0}, 64'd0);
    chk("reset err", {32'd0, err0}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven exhaustive runs on instance 0
    for (int t = 0; t < 5; t++) begin
      f0_vec = tbl[t].fvec;
      f0_xor = tbl[t].fxor;
      run(0, 100, edges, vcnt);
      chk($sformatf("t%0d edges", t), 64'(edges), 64'd18);
      chk($sformatf("t%0d err", t), {32'd0, err0}, 64'(tbl[t].exp_err));
      chk($sformatf("t%0d pass", t), {63'd0, pass0}, {63'd0, tbl[t].exp_pass});
      chk($sformatf("t%0d fail_vector", t), {60'd0, fv0}, {60'd0, tbl[t].exp_fv});
      chk($sformatf("t%0d fail_expected", t), {60'd0, fe0}, {60'd0, tbl[t].exp_fe});
      chk($sformatf("t%0d fail_got", t), {60'd0, fg0}, {60'd0, tbl[t].exp_fg});
      bad = 0;
      for (int i = 0; i < seen_q.size(); i++) if (seen_q[i] !== 8'(i)) bad++;
      chk($sformatf("t%0d seq", t), 64'(bad + (seen_q.size() != 16 ? 1 : 0)), 64'd0);
    end

    // Random single-fault runs on instance 0
    for (int t = 0; t < 4; t++) begin
      rv = 4'($urandom_range(0, 15));
      rx = 4'($urandom_range(0, 15));
      f0_vec = rv;
      f0_xor = rx;
      run(0, 100, edges, vcnt);
      chk("r0 err", {32'd0, err0}, (rx == 4'h0) ? 64'd0 : 64'd1);
      chk("r0 pass", {63'd0, pass0}, (rx == 4'h0) ? 64'd1 : 64'd0);
      chk("r0 fail_got", {60'd0, fg0}, (rx == 4'h0) ? 64'd0 : {60'd0, rv ^ rx});
    end

    // Abort on first error
    run(1, 100, edges, vcnt);
    chk("abort edges", 64'(edges), 64'd3);
    chk("abort err", {32'd0, err1}, 64'd1);
    chk("abort pass", {63'd0, pass1}, 64'd0);
    chk("abort fail_vector", {60'd0, fv1}, 64'd0);
    chk("abort fail_got", {60'd0, fg1}, 64'hF);
    chk("abort vcount", 64'(vcnt), 64'd3);
    bad = 0;
    repeat (4) begin
      if (dut_valid1 !== 1'b0 || done1 !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("abort hold", 64'(bad), 64'd0);

    // LFSR sequence
    run(2, 100, edges, vcnt);
    chk("lfsr edges", 64'(edges), 64'd6);
    chk("lfsr pass", {63'd0, pass2}, 64'd1);
    chk("lfsr count", 64'(seen_q.size()), 64'd5);
    if (seen_q.size() == 5) begin
      chk("lfsr v0", {56'd0, seen_q[0]}, 64'h01);
      chk("lfsr v1", {56'd0, seen_q[1]}, 64'hB8);
      chk("lfsr v2", {56'd0, seen_q[2]}, 64'h5C);
      chk("lfsr v3", {56'd0, seen_q[3]}, 64'h2E);
      chk("lfsr v4", {56'd0, seen_q[4]}, 64'h17);
    end

    // LATENCY 0 with gaps: x only in gaps, then x in slot 7
    x3_en = 1'b0;
    run(3, 100, edges, vcnt);
    chk("gap edges", 64'(edges), 64'd31);
    chk("gap err", {32'd0, err3}, 64'd0);
    chk("gap pass", {63'd0, pass3}, 64'd1);
    x3_en = 1'b1;
    run(3, 100, edges, vcnt);
    chk("xslot err", {32'd0, err3}, 64'd1);
    chk("xslot fail_vector", {60'd0, fv3}, 64'd7);
    chk("xslot fail_expected", {60'd0, fe3}, 64'd7);
    chk("xslot fail_got differs", {63'd0, (fg3 !== 4'd7)}, 64'd1);
    chk("xslot pass", {63'd0, pass3}, 64'd0);

    // Randomized runs on instance 4 against a sequence-level model
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) f4[i] = 8'h00;
      v = 8'h5A;
      for (int k = 0; k < 20; k++) begin
        seq[k] = v;
        v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
      end
      for (int k = 0; k < 20; k++)
        if ($urandom_range(0, 5) == 0) f4[seq[k]] = 8'($urandom_range(1, 255));
      nf = 0; first_k = -1; abort_k = -1;
      for (int k = 0; k < 20; k++) begin
        if (f4[seq[k]] != 8'h00) begin
          if (first_k < 0) first_k = k;
          nf++;
          if (nf == 3 && abort_k < 0) abort_k = k;
        end
      end
      exp_edges = (abort_k >= 0) ? abort_k * 3 + 1 + 3 : 20 * 3 - 2 + 3;
      exp_vcnt  = (abort_k >= 0) ? ((abort_k + 2 > 20) ? 20 : abort_k + 2) : 20;
      run(4, 200, edges, vcnt);
      chk($sformatf("rnd%0d edges", t), 64'(edges), 64'(exp_edges));
      chk($sformatf("rnd%0d err", t), {32'd0, err4}, 64'((nf > 3) ? 3 : nf));
      chk($sformatf("rnd%0d pass", t), {63'd0, pass4}, (nf == 0) ? 64'd1 : 64'd0);
      chk($sformatf("rnd%0d vcount", t), 64'(vcnt), 64'(exp_vcnt));
      bad = 0;
      for (int i = 0; i < seen_q.size() && i < 20; i++) if (seen_q[i] !== seq[i]) bad++;
      chk($sformatf("rnd%0d seq", t), 64'(bad), 64'd0);
      if (first_k >= 0) begin
        chk($sformatf("rnd%0d fail_vector", t), {56'd0, fv4}, {56'd0, seq[first_k]});
        chk($sformatf("rnd%0d fail_got", t), {56'd0, fg4}, {56'd0, seq[first_k] ^ f4[seq[first_k]]});
      end
    end

    // Asynchronous reset mid-run, then a clean restart
    f0_vec = 4'd1; f0_xor = 4'h4;
    start_m[0] = 1'b1;
    @(negedge clk);
    start_m[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset err", {32'd0, err0}, 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", {63'd0, busy0}, 64'd0);
    chk("async done", {63'd0, done0}, 64'd0);
    chk("async valid", {63'd0, dut_valid0}, 64'd0);
    chk("async err", {32'd0, err0}, 64'd0);
    chk("async fail_vector", {60'd0, fv0}, 64'd0);
    chk("async done4", {63'd0, done4}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    f0_xor = 4'h0;
    run(0, 100, edges, vcnt);
    chk("restart edges", 64'(edges), 64'd18);
    chk("restart pass", {63'd0, pass0}, 64'd1);
    chk("restart first", (seen_q.size() > 0) ? {56'd0, seen_q[0]} : 64'hFFFF, 64'd0);
    chk("restart count", 64'(vcnt), 64'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
